// File: rtl/decode_fetch_queue_if.sv
// Fetch/decode-side bundle of the instruction queue. The fetch and decode
// stages drive the master side; the queue itself uses the slave side.
interface decode_fetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int PC_W    = 64
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TAKE_W = $clog2(DEC_W + 1);

  logic [FETCH_W-1:0]      in_valid;
  logic [FETCH_W*PC_W-1:0] in_pc;
  logic [FETCH_W*32-1:0]   in_instr;
  logic [FETCH_W-1:0]      in_pred;
  logic                    in_ready;

  logic [DEC_W-1:0]        out_valid;
  logic [DEC_W*PC_W-1:0]   out_pc;
  logic [DEC_W*32-1:0]     out_instr;
  logic [DEC_W-1:0]        out_pred;
  logic [DEC_W-1:0]        out_misalign;
  logic [TAKE_W-1:0]       out_take;
  logic [CNT_W-1:0]        count;

  modport master (
    output in_valid, in_pc, in_instr, in_pred, out_take,
    input  in_ready, out_valid, out_pc, out_instr, out_pred, out_misalign, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_pred, out_take,
    output in_ready, out_valid, out_pc, out_instr, out_pred, out_misalign, count
  );
endinterface

// File: rtl/decode_fetch_queue.sv
// Circular instruction buffer between fetch and decode: pushes up to FETCH_W
// entries and presents up to DEC_W in program order; flushed on redirect.
module decode_fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int PC_W    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  decode_fetch_queue_if.slave q
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_W_C = CNT_W'(FETCH_W);

  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic             mem_pred  [DEPTH];
  logic             mem_mis   [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_r;

  logic [CNT_W-1:0]   n_push, push_cnt, n_pop, take_ext;
  logic [FETCH_W-1:0] valid_prefix;
  logic               in_prefix, ready, accept;
  logic [PTR_W-1:0]   wr_idx [FETCH_W];
  logic [PTR_W-1:0]   rd_idx [DEC_W];

  // Only the contiguous run of valid lanes starting at lane 0 is pushed.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    n_push       = '0;
    valid_prefix = '0;
    in_prefix    = 1'b1;
    for (int i = 0; i < FETCH_W; i++) begin
      if (in_prefix && q.in_valid[i]) begin
        n_push          = n_push + CNT_W'(1);
        valid_prefix[i] = 1'b1;
      end else begin
        in_prefix = 1'b0;
      end
    end
  end

  // Credit is based on the registered occupancy only; same-cycle pops do not help.
  assign ready    = (DEPTH_C - count_r) >= FETCH_W_C;
  assign accept   = ready && !flush;
  assign push_cnt = accept ? n_push : '0;
  assign take_ext = CNT_W'(q.out_take);
  assign n_pop    = flush ? '0 : ((take_ext > count_r) ? count_r : take_ext);

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) wr_idx[i] = tail + PTR_W'(i);
    for (int i = 0; i < DEC_W; i++)   rd_idx[i] = head + PTR_W'(i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      head    <= head + PTR_W'(n_pop);
      tail    <= tail + PTR_W'(push_cnt);
      count_r <= count_r + push_cnt - n_pop;
    end
  end

  // NOTE: the entry storage has no reset; an entry is only visible once count
  // covers it, and every such entry was written by a push first.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (accept && (CNT_W'(i) < n_push)) begin
        mem_pc[wr_idx[i]]    <= q.in_pc[i*PC_W +: PC_W];
        mem_pred[wr_idx[i]]  <= q.in_pred[i];
        mem_mis[wr_idx[i]]   <= |q.in_pc[i*PC_W +: 2];
        mem_instr[wr_idx[i]] <= (|q.in_pc[i*PC_W +: 2]) ? 32'h0 : q.in_instr[i*32 +: 32];
      end
    end
  end

  always_comb begin
    q.out_valid    = '0;
    q.out_pc       = '0;
    q.out_instr    = '0;
    q.out_pred     = '0;
    q.out_misalign = '0;
    for (int i = 0; i < DEC_W; i++) begin
      q.out_valid[i]         = count_r > CNT_W'(i);
      q.out_pc[i*PC_W +: PC_W] = mem_pc[rd_idx[i]];
      q.out_instr[i*32 +: 32]  = mem_instr[rd_idx[i]];
      q.out_pred[i]          = mem_pred[rd_idx[i]];
      q.out_misalign[i]      = mem_mis[rd_idx[i]];
    end
  end

  assign q.in_ready = ready;
  assign q.count    = count_r;

  // Protocol checks on the producer and consumer; the RTL clamps/masks regardless.
  a_take_le_count: assert property (@(posedge clk) disable iff (!reset)
    !flush |-> take_ext <= count_r);
  a_valid_prefix: assert property (@(posedge clk) disable iff (!reset)
    q.in_valid == valid_prefix);
endmodule
